// File: rtl/iob_sp_ram_arbiter.sv
// iob_sp_ram_arbiter: round-robin sharing of one single-port RAM between two requesters,
// with a zero-fill walk of the RAM after reset and on clear.
module iob_sp_ram_arbiter #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    output logic              init_done,
    input  logic              p0_valid,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_ready,
    output logic              p0_rsp_valid,
    input  logic              p1_valid,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_ready,
    output logic              p1_rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);
    typedef enum logic {INIT, RUN} state_t;
    state_t            state;
    logic [ADDR_W-1:0] init_cnt;
    logic              last_grant, rsp0, rsp1, rsp_rd;
    logic              run, g0, g1;
    assign run = state == RUN;
    // On contention the port that was not served last wins.
    assign g0 = run & p0_valid & (~p1_valid | last_grant);
    assign g1 = run & p1_valid & (~p0_valid | ~last_grant);
    assign init_done    = run;
    assign p0_ready     = g0;
    assign p1_ready     = g1;
    assign p0_rsp_valid = rsp0;
    assign p1_rsp_valid = rsp1;
    assign rsp_rdata    = ((rsp0 | rsp1) & rsp_rd) ? ram_dout : '0;
    // The INIT walk drives the RAM from state alone, so gate it while reset is held.
    assign ram_en   = rst_n & (~run | g0 | g1);
    assign ram_we   = rst_n & (~run | (g0 & p0_we) | (g1 & p1_we));
    assign ram_addr = ~run ? init_cnt : g0 ? p0_addr : g1 ? p1_addr : '0;
    assign ram_din  = g0 ? p0_wdata : g1 ? p1_wdata : '0;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= INIT;
            init_cnt   <= '0;
            last_grant <= 1'b1;
            rsp0       <= 1'b0;
            rsp1       <= 1'b0;
            rsp_rd     <= 1'b0;
        end else begin
            rsp0   <= g0;
            rsp1   <= g1;
            rsp_rd <= g0 ? ~p0_we : ~p1_we;
            if (g0 | g1) last_grant <= g1;
            if (!run) begin
                init_cnt <= clear ? '0 : init_cnt + 1'b1;
                if (!clear && &init_cnt) state <= RUN;
            end else if (clear) begin
                state <= INIT;
            end
        end
    end
endmodule
